// File: rtl/ex_stage_mc.sv
// Execute stage for the mips_16 pipeline: single-cycle ALU plus an iterative
// shift-add multiplier that stalls ID for DATA_W cycles and drains bubbles into MEM.
module ex_stage_mc #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SIDE_W   = 22,
    parameter int unsigned DEST_LSB = 1,
    parameter int unsigned DEST_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        in_cmd,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [SIDE_W-1:0] out_side,
    output logic              stall_out,
    output logic              ex_busy,
    output logic [DEST_W-1:0] ex_op_dest
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    localparam logic [3:0] CmdAdd = 4'd1;
    localparam logic [3:0] CmdSub = 4'd2;
    localparam logic [3:0] CmdAnd = 4'd3;
    localparam logic [3:0] CmdOr  = 4'd4;
    localparam logic [3:0] CmdXor = 4'd5;
    localparam logic [3:0] CmdSl  = 4'd6;
    localparam logic [3:0] CmdSr  = 4'd7;
    localparam logic [3:0] CmdMul = 4'd8;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q;
    logic [SH_W-1:0]   cnt_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [SIDE_W-1:0] side_q;

    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] acc_next;
    logic              mul_start;
    logic              mul_last;

    always_comb begin
        alu_res = '0;
        unique case (in_cmd)
            CmdAdd:  alu_res = in_src1 + in_src2;
            CmdSub:  alu_res = in_src1 - in_src2;
            CmdAnd:  alu_res = in_src1 & in_src2;
            CmdOr:   alu_res = in_src1 | in_src2;
            CmdXor:  alu_res = in_src1 ^ in_src2;
            CmdSl:   alu_res = in_src1 << in_src2[SH_W-1:0];
            CmdSr:   alu_res = in_src1 >> in_src2[SH_W-1:0];
            default: alu_res = '0;
        endcase
    end

    assign acc_next  = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign mul_start = (state_q == StIdle) && in_valid && (in_cmd == CmdMul);
    assign mul_last  = (state_q == StBusy) && (cnt_q == SH_W'(DATA_W - 1));

    // Released in the final BUSY cycle so ID advances on the retiring edge.
    assign stall_out  = mul_start || ((state_q == StBusy) && !mul_last);
    assign ex_op_dest = (state_q == StBusy) ? side_q[DEST_LSB +: DEST_W]
                                            : in_side[DEST_LSB +: DEST_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            side_q     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_side   <= '0;
            ex_busy    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mul_start) begin
                        acc_q      <= '0;
                        mcand_q    <= in_src1;
                        mplier_q   <= in_src2;
                        side_q     <= in_side;
                        cnt_q      <= '0;
                        state_q    <= StBusy;
                        ex_busy    <= 1'b1;
                        out_valid  <= 1'b0;
                        out_result <= '0;
                        out_side   <= '0;
                    end else if (in_valid) begin
                        out_valid  <= 1'b1;
                        out_result <= alu_res;
                        out_side   <= in_side;
                    end else begin
                        out_valid  <= 1'b0;
                        out_result <= '0;
                        out_side   <= '0;
                    end
                end
                StBusy: begin
                    acc_q    <= acc_next;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + SH_W'(1);
                    if (mul_last) begin
                        out_valid  <= 1'b1;
                        out_result <= acc_next;
                        out_side   <= side_q;
                        state_q    <= StIdle;
                        ex_busy    <= 1'b0;
                    end else begin
                        out_valid  <= 1'b0;
                        out_result <= '0;
                        out_side   <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Self-checking bench for ex_stage_mc: directed literal checks, a cycle-level
// reference model compared every cycle, randomized traffic, and a 32-bit instance.
module tb_ex_stage_mc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        v = 1'b0;
    logic [3:0]  cmd = '0;
    logic [15:0] a = '0, b = '0;
    logic [21:0] side = '0;
    logic        ov, stall, busy;
    logic [15:0] ores;
    logic [21:0] oside;
    logic [2:0]  dest;

    ex_stage_mc #(.DATA_W(16), .SIDE_W(22), .DEST_LSB(1), .DEST_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(v), .in_cmd(cmd), .in_src1(a), .in_src2(b),
        .in_side(side), .out_valid(ov), .out_result(ores), .out_side(oside),
        .stall_out(stall), .ex_busy(busy), .ex_op_dest(dest)
    );

    // 32-bit instance
    logic        v2 = 1'b0;
    logic [3:0]  cmd2 = '0;
    logic [31:0] a2 = '0, b2 = '0;
    logic [21:0] side2 = '0;
    logic        ov2, stall2, busy2;
    logic [31:0] ores2;
    logic [21:0] oside2;
    logic [2:0]  dest2;

    ex_stage_mc #(.DATA_W(32), .SIDE_W(22), .DEST_LSB(1), .DEST_W(3)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_cmd(cmd2), .in_src1(a2), .in_src2(b2),
        .in_side(side2), .out_valid(ov2), .out_result(ores2), .out_side(oside2),
        .stall_out(stall2), .ex_busy(busy2), .ex_op_dest(dest2)
    );

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic longint unsigned ref_op(input int w, input int op,
                                               input longint unsigned x,
                                               input longint unsigned y);
        longint unsigned m = (64'd1 << w) - 64'd1;
        int sh = int'(y % longint'(w));
        longint unsigned r;
        case (op)
            1:       r = x + y;
            2:       r = x - y;
            3:       r = x & y;
            4:       r = x | y;
            5:       r = x ^ y;
            6:       r = x << sh;
            7:       r = x >> sh;
            8:       r = x * y;
            default: r = 0;
        endcase
        return r & m;
    endfunction

    // Reference model: an instruction either retires next cycle, or a MUL
    // occupies the stage for 16 cycles and retires its precomputed product.
    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [15:0] m_prod = '0;
    logic [21:0] m_side = '0;
    logic        e_valid = 1'b0;
    logic [15:0] e_res = '0;
    logic [21:0] e_side = '0;
    bit          last_stall = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_left <= 0;
            e_valid <= 1'b0; e_res <= '0; e_side <= '0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                e_valid <= 1'b1; e_res <= m_prod; e_side <= m_side;
            end else begin
                e_valid <= 1'b0; e_res <= '0; e_side <= '0;
            end
        end else if (v && cmd == 4'd8) begin
            m_busy <= 1'b1; m_left <= 16;
            m_prod <= 16'(ref_op(16, 8, 64'(a), 64'(b)));
            m_side <= side;
            e_valid <= 1'b0; e_res <= '0; e_side <= '0;
        end else if (v) begin
            e_valid <= 1'b1; e_res <= 16'(ref_op(16, int'(cmd), 64'(a), 64'(b))); e_side <= side;
        end else begin
            e_valid <= 1'b0; e_res <= '0; e_side <= '0;
        end
    end

    function automatic bit model_stall();
        return (!m_busy && v && cmd == 4'd8) || (m_busy && m_left > 1);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid",  64'(ov),    64'(e_valid));
            chk("model_result", 64'(ores),  64'(e_res));
            chk("model_side",   64'(oside), 64'(e_side));
            chk("model_busy",   64'(busy),  64'(m_busy));
            chk("model_stall",  64'(stall), 64'(model_stall()));
            chk("model_dest",   64'(dest),  64'(m_busy ? m_side[3:1] : side[3:1]));
        end
        last_stall <= model_stall();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(ov), 64'd0);
        chk("rst_result", 64'(ores), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);

        // ADD overflow into bit 15
        tick();
        v = 1'b1; cmd = 4'd1; a = 16'h7FFF; b = 16'h0001; side = 22'h155555;
        @(negedge clk);
        chk("add_stall", 64'(stall), 64'd0);
        tick();
        v = 1'b0;
        @(negedge clk);
        chk("add_valid", 64'(ov), 64'd1);
        chk("add_result", 64'(ores), 64'h8000);
        chk("add_side", 64'(oside), 64'h155555);

        // SUB, SL, SR back to back
        tick();
        v = 1'b1; cmd = 4'd2; a = 16'h0000; b = 16'h0001; side = 22'h0;
        tick();
        cmd = 4'd6; a = 16'h0001; b = 16'h0011;
        @(negedge clk);
        chk("sub_result", 64'(ores), 64'hFFFF);
        tick();
        cmd = 4'd7; a = 16'h8000; b = 16'h000F;
        @(negedge clk);
        chk("sl_result", 64'(ores), 64'h0002);
        tick();
        v = 1'b0;
        @(negedge clk);
        chk("sr_result", 64'(ores), 64'h0001);
        chk("sr_valid", 64'(ov), 64'd1);

        // MUL 0x00FF * 0x0101, dest 5
        tick();
        v = 1'b1; cmd = 4'd8; a = 16'h00FF; b = 16'h0101; side = 22'(5 << 1);
        for (int c = 0; c <= 17; c++) begin
            @(negedge clk);
            chk("mul_stall", 64'(stall), 64'(c <= 15));
            if (c <= 16) chk("mul_dest", 64'(dest), 64'd5);
            chk("mul_valid", 64'(ov), 64'(c == 17));
            if (c == 17) chk("mul_result", 64'(ores), 64'hFFFF);
            tick();
            if (c == 16) v = 1'b0;
        end

        // MUL followed immediately by ADD
        v = 1'b1; cmd = 4'd8; a = 16'h1234; b = 16'h0100; side = 22'h3;
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            if (c == 17) begin
                chk("mul2_valid", 64'(ov), 64'd1);
                chk("mul2_result", 64'(ores), 64'h3400);
            end
            if (c == 18) begin
                chk("add2_valid", 64'(ov), 64'd1);
                chk("add2_result", 64'(ores), 64'h0007);
            end
            tick();
            if (c == 16) begin cmd = 4'd1; a = 16'd3; b = 16'd4; end
            if (c == 17) v = 1'b0;
        end

        // Reset in cycle 8 of a MUL
        v = 1'b1; cmd = 4'd8; a = 16'h0ABC; b = 16'h0033; side = 22'h2;
        for (int c = 0; c < 8; c++) tick();
        rst = 1'b1; v = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", 64'(ov), 64'd0);
        chk("abort_result", 64'(ores), 64'd0);
        chk("abort_side", 64'(oside), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_stall", 64'(stall), 64'd0);
        for (int c = 0; c < 12; c++) begin
            tick();
            @(negedge clk);
            chk("abort_no_product", 64'(ov), 64'd0);
        end

        // Randomized traffic, holding inputs while stalled
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 299) == 0);
            if (!last_stall) begin
                v    = ($urandom_range(0, 3) != 0);
                cmd  = ($urandom_range(0, 5) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
                a    = 16'($urandom);
                b    = 16'($urandom);
                side = 22'($urandom);
            end
        end
        tick();
        rst = 1'b0; v = 1'b0;
        tick();

        // 32-bit instance: MUL of all ones, then SL by 0x21
        v2 = 1'b1; cmd2 = 4'd8; a2 = 32'hFFFFFFFF; b2 = 32'hFFFFFFFF;
        for (int c = 0; c <= 32; c++) begin
            @(negedge clk);
            if (c == 0) chk("w32_stall", 64'(stall2), 64'd1);
            if (c == 32) begin
                chk("w32_stall_last", 64'(stall2), 64'd0);
                chk("w32_early", 64'(ov2), 64'd0);
            end
            tick();
        end
        cmd2 = 4'd6; a2 = 32'h1; b2 = 32'h21;
        @(negedge clk);
        chk("w32_mul_valid", 64'(ov2), 64'd1);
        chk("w32_mul_result", 64'(ores2), 64'h1);
        tick();
        v2 = 1'b0;
        @(negedge clk);
        chk("w32_sl_valid", 64'(ov2), 64'd1);
        chk("w32_sl_result", 64'(ores2), 64'h2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
